fetch_bundle_queue: RTL and testbench
=====================================

# fetch_bundle_queue

Four-wide instruction bundle FIFO between the branch handler and decode. It captures each filtered 4-instruction bundle with its fetch PC and immediate-jump flags, and presents the oldest bundle to decode under a valid/ready handshake. When the queue is full it back-pressures fetch through `stall_fetch`. On dispatch it NOPs immediate jumps, and it empties completely on a ROB mispredict flush.

## Interface
**Parameters**
- `DEPTH`, default 4: number of bundle entries. Must be a power of 2 and ≥ 2.
- `PTR_W`, default 2: pointer width, equal to log2(`DEPTH`).

**Ports** (clock and reset first)
- `clk`  in  1: single clock. All state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `flush`  in  1: mispredict flush from the ROB.
- `push`  in  1: the branch handler presents a bundle this cycle.
- `pc_in`  in  16: fetch PC of slot 0.
- `inst_in0`..`inst_in3`  in  16 each: filtered instructions. `16'b0` means NOP.
- `isImJmp_in`  in  4: immediate-jump flags. Bit 3 maps to slot 0, bit 0 to slot 3.
- `dec_ready`  in  1: decode accepts the head bundle this cycle.
- `stall_fetch`  out  1: queue full. Fetch must hold its PC.
- `out_valid`  out  1: head bundle valid.
- `pc_out`  out  16: PC of the head bundle.
- `inst_out0`..`inst_out3`  out  16 each: head instructions.
- `count`  out  `PTR_W`+1: number of occupied entries.

## Operation
- **Storage:** `DEPTH` entries. Each entry holds {pc, 4×inst, isImJmp}, 84 bits. Read pointer `rd_ptr` and write pointer `wr_ptr` are `PTR_W` bits wide and wrap modulo `DEPTH`. Occupancy is held in `count`.
- **Write condition:** `wr_en = push & !flush & (count != DEPTH) & (|{inst_in0,inst_in1,inst_in2,inst_in3})`.
  - An all-zero bundle is dropped. This covers bundles fully NOPed by a stall, a hold, or a taken branch in slot 0.
- **Read condition:** `rd_en = out_valid & dec_ready & !flush`.
- **Pointer and count update:**
  - `wr_en` advances `wr_ptr`.
  - `rd_en` advances `rd_ptr`.
  - `count` changes by +1 on write only, −1 on read only, and 0 when both or neither occur.
- **Full:** a push while full is ignored and writes no storage. `stall_fetch` is already high in that case, so upstream is holding.
- **Empty:** a pop while empty is impossible, because `out_valid` is 0.
- **Flush:** takes priority over push and pop. The next state is `rd_ptr = wr_ptr = 0` and `count = 0`. Storage contents are don't-care.
- **Outputs:** `out_valid = (count != 0)`. `pc_out` and `inst_outN` come combinationally from entry[`rd_ptr`].
  - `inst_outN` is forced to `16'b0` when `out_valid = 0`.
  - `inst_outN` is forced to `16'b0` when the stored isImJmp bit for slot N is set. Immediate jumps are fully handled by fetch and are removed here.
  - `pc_out` is forced to 0 when `out_valid = 0`.
- **Back-pressure:** `stall_fetch = (count == DEPTH)`. It is combinational from registered state and has no combinational path from any input.

## Timing
- **Reset:** `count = 0` and pointers = 0. As a result `out_valid = 0`, `stall_fetch = 0`, and `pc_out` and all `inst_outN` read 0. Storage is not reset.
- **Latency:** a bundle pushed in cycle N is visible on the outputs in cycle N+1 at the earliest. There is no same-cycle bypass.
- **Handshake:** a transfer occurs on a cycle with `out_valid & dec_ready`.
  - The head advances at the following edge.
  - If `out_valid` is high and `dec_ready` is low, the outputs stay stable.
- **Push and pop together when full:** the pop completes and the push is dropped, because `stall_fetch` was high that cycle. `count` becomes `DEPTH`−1.
- **Push and pop together when empty:** only the push takes effect. `count` becomes 1.
- **Push and pop together otherwise:** both take effect and `count` is unchanged.
- **Flush timing:** `flush` in cycle N gives `out_valid = 0` and `stall_fetch = 0` in cycle N+1. A push in cycle N is discarded.
- **Reset mid-operation:** asynchronous. The outputs go to their reset values immediately, without waiting for a clock edge.
- **Wrap-around:** after `DEPTH` pushes and `DEPTH` pops, both pointers return to 0 with no lost or duplicated bundle.

## Test plan
1. **Reset, single push, pop.**
   - Stimulus: reset, then push pc=0x0010 with insts {0x1234, 0x2345, 0x3456, 0x4567}, `dec_ready` = 0.
   - Required: `out_valid` = 1 the next cycle with the same values on the outputs, `count` = 1. Raising `dec_ready` then gives `out_valid` = 0 and `count` = 0.
2. **Fill to full.**
   - Stimulus: push 4 distinct bundles with `dec_ready` = 0.
   - Required: `stall_fetch` = 1 after the 4th, `count` = 4. A 5th push is ignored. Popping gives the bundles in order pc 0x00, 0x04, 0x08, 0x0C, and `stall_fetch` drops after the first pop.
3. **NOP bundle and immediate-jump removal.**
   - Stimulus: push an all-zero bundle, then push insts {0x1111, 0xF004, 0, 0} with `isImJmp_in` = 4'b0100.
   - Required: `count` stays 0 after the all-zero bundle. The second bundle is output as {0x1111, 0x0000, 0, 0}.
4. **Simultaneous push and pop at full and at empty.**
   - Required at full: `count` goes 4 → 3. Required at empty: `count` goes 0 → 1.
   - Required: a 20-cycle random push/pop run matches a reference model with no order violation across pointer wrap.
5. **Flush with push.**
   - Stimulus: 3 entries queued, then `flush` together with `push` and `dec_ready`.
   - Required: next cycle `count` = 0, `out_valid` = 0, `stall_fetch` = 0. No bundle is accepted and none is popped.
6. **Asynchronous reset mid-traffic.**
   - Stimulus: assert `rst_n` = 0 between clock edges while the queue is full.
   - Required: `stall_fetch`, `out_valid` and `count` go to 0 immediately.

Source files
------------

// File: rtl/fetch_bundle_queue.sv
// fetch_bundle_queue
//   Four-wide instruction bundle FIFO sitting between the branch handler and
//   decode. Each entry holds the fetch PC, four 16-bit instructions and the
//   per-slot immediate-jump flags. The oldest bundle is presented to decode
//   under a valid/ready handshake. Immediate jumps are NOPed on the way out,
//   all-zero bundles are never stored, and a ROB flush empties the queue.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 mispredict flush (beats push and pop)
//   push                  branch handler presents a bundle this cycle
//   pc_in                 fetch PC of slot 0
//   inst_in0..inst_in3    filtered instructions (16'b0 = NOP)
//   isImJmp_in            immediate-jump flags, bit 3 = slot 0 .. bit 0 = slot 3
//   dec_ready             decode accepts the head bundle this cycle
//   stall_fetch           queue full, fetch must hold its PC
//   out_valid             head bundle valid
//   pc_out                head PC (0 when empty)
//   inst_out0..inst_out3  head instructions (0 when empty or immediate jump)
//   count                 number of occupied entries
module fetch_bundle_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [15:0]      pc_in,
    input  logic [15:0]      inst_in0,
    input  logic [15:0]      inst_in1,
    input  logic [15:0]      inst_in2,
    input  logic [15:0]      inst_in3,
    input  logic [3:0]       isImJmp_in,
    input  logic             dec_ready,
    output logic             stall_fetch,
    output logic             out_valid,
    output logic [15:0]      pc_out,
    output logic [15:0]      inst_out0,
    output logic [15:0]      inst_out1,
    output logic [15:0]      inst_out2,
    output logic [15:0]      inst_out3,
    output logic [PTR_W:0]   count
);

    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    // Bundle storage; deliberately not reset, contents are don't-care when empty.
    logic [15:0] pc_mem   [DEPTH];
    logic [15:0] inst_mem [DEPTH][4];
    logic [3:0]  jmp_mem  [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   cnt_q;

    logic any_inst;
    logic full;
    logic wr_en;
    logic rd_en;

    assign full      = (cnt_q == FULL_CNT);
    assign out_valid = (cnt_q != '0);
    assign any_inst  = |{inst_in0, inst_in1, inst_in2, inst_in3};

    // A bundle NOPed entirely upstream carries nothing for decode, so it is dropped.
    assign wr_en = push & ~flush & ~full & any_inst;
    assign rd_en = out_valid & dec_ready & ~flush;

    assign stall_fetch = full;
    assign count       = cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            pc_mem[wr_ptr]      <= pc_in;
            inst_mem[wr_ptr][0] <= inst_in0;
            inst_mem[wr_ptr][1] <= inst_in1;
            inst_mem[wr_ptr][2] <= inst_in2;
            inst_mem[wr_ptr][3] <= inst_in3;
            jmp_mem[wr_ptr]     <= isImJmp_in;
        end
    end

    // Head read. Flag bit (3-N) belongs to slot N; a set flag means fetch has
    // already redirected on that immediate jump, so decode sees a NOP there.
    always_comb begin
        pc_out    = 16'h0000;
        inst_out0 = 16'h0000;
        inst_out1 = 16'h0000;
        inst_out2 = 16'h0000;
        inst_out3 = 16'h0000;
        if (out_valid) begin
            pc_out = pc_mem[rd_ptr];
            if (!jmp_mem[rd_ptr][3]) inst_out0 = inst_mem[rd_ptr][0];
            if (!jmp_mem[rd_ptr][2]) inst_out1 = inst_mem[rd_ptr][1];
            if (!jmp_mem[rd_ptr][1]) inst_out2 = inst_mem[rd_ptr][2];
            if (!jmp_mem[rd_ptr][0]) inst_out3 = inst_mem[rd_ptr][3];
        end
    end

endmodule

// File: tb/tb_fetch_bundle_queue.sv
// Testbench for fetch_bundle_queue: directed stimulus feeds an expected-bundle
// queue; an independent monitor checks every bundle decode accepts.
module tb_fetch_bundle_queue;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        push;
    logic [15:0] pc_in;
    logic [15:0] inst_in0, inst_in1, inst_in2, inst_in3;
    logic [3:0]  isImJmp_in;
    logic        dec_ready;
    logic        stall_fetch;
    logic        out_valid;
    logic [15:0] pc_out;
    logic [15:0] inst_out0, inst_out1, inst_out2, inst_out3;
    logic [2:0]  count;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] i0;
        logic [15:0] i1;
        logic [15:0] i2;
        logic [15:0] i3;
    } bundle_t;

    bundle_t exp_q[$];
    int      mdl_cnt;
    int      checks;
    int      errors;

    fetch_bundle_queue #(.DEPTH(4), .PTR_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .push       (push),
        .pc_in      (pc_in),
        .inst_in0   (inst_in0),
        .inst_in1   (inst_in1),
        .inst_in2   (inst_in2),
        .inst_in3   (inst_in3),
        .isImJmp_in (isImJmp_in),
        .dec_ready  (dec_ready),
        .stall_fetch(stall_fetch),
        .out_valid  (out_valid),
        .pc_out     (pc_out),
        .inst_out0  (inst_out0),
        .inst_out1  (inst_out1),
        .inst_out2  (inst_out2),
        .inst_out3  (inst_out3),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: whenever decode takes the head bundle, compare against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && dec_ready && !flush) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got pc 0x%0h, expected no bundle", pc_out);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                chk("pop_pc", {16'h0, pc_out}, {16'h0, e.pc});
                chk("pop_inst0", {16'h0, inst_out0}, {16'h0, e.i0});
                chk("pop_inst1", {16'h0, inst_out1}, {16'h0, e.i1});
                chk("pop_inst2", {16'h0, inst_out2}, {16'h0, e.i2});
                chk("pop_inst3", {16'h0, inst_out3}, {16'h0, e.i3});
            end
        end
    end

    // One clock of stimulus; expectations are recorded before the edge.
    task automatic cycle(input logic p, input logic [15:0] pc,
                         input logic [15:0] i0, input logic [15:0] i1,
                         input logic [15:0] i2, input logic [15:0] i3,
                         input logic [3:0] jm, input logic rdy, input logic fl);
        bit wr;
        bit rd;
        bundle_t e;
        push = p; pc_in = pc;
        inst_in0 = i0; inst_in1 = i1; inst_in2 = i2; inst_in3 = i3;
        isImJmp_in = jm; dec_ready = rdy; flush = fl;
        wr = p && !fl && (mdl_cnt != 4) && ((i0 | i1 | i2 | i3) != 16'h0);
        rd = (mdl_cnt != 0) && rdy && !fl;
        if (fl) begin
            exp_q.delete();
            mdl_cnt = 0;
        end else begin
            if (wr) begin
                e.pc = pc;
                e.i0 = jm[3] ? 16'h0 : i0;
                e.i1 = jm[2] ? 16'h0 : i1;
                e.i2 = jm[1] ? 16'h0 : i2;
                e.i3 = jm[0] ? 16'h0 : i3;
                exp_q.push_back(e);
            end
            mdl_cnt = mdl_cnt + (wr ? 1 : 0) - (rd ? 1 : 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0, rdy, 1'b0);
    endtask

    task automatic push_b(input logic [15:0] pc, input logic rdy);
        cycle(1'b1, pc, pc + 16'h1001, pc + 16'h2002, pc + 16'h3003, pc + 16'h4004, 4'b0, rdy, 1'b0);
    endtask

    task automatic chk_state(input string nm);
        chk({nm, "_count"}, {29'h0, count}, mdl_cnt);
        chk({nm, "_valid"}, {31'h0, out_valid}, (mdl_cnt != 0) ? 1 : 0);
        chk({nm, "_stall"}, {31'h0, stall_fetch}, (mdl_cnt == 4) ? 1 : 0);
    endtask

    task automatic drain();
        for (int k = 0; k < 6; k++) idle(1'b1);
        chk_state("drain");
        chk("drain_scoreboard_empty", exp_q.size(), 0);
    endtask

    initial begin
        checks = 0; errors = 0; mdl_cnt = 0;
        rst_n = 1'b0; flush = 1'b0; push = 1'b0; pc_in = '0;
        inst_in0 = '0; inst_in1 = '0; inst_in2 = '0; inst_in3 = '0;
        isImJmp_in = '0; dec_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'h0, out_valid}, 0);
        chk("reset_stall", {31'h0, stall_fetch}, 0);
        chk("reset_count", {29'h0, count}, 0);
        chk("reset_pc", {16'h0, pc_out}, 0);
        chk("reset_inst0", {16'h0, inst_out0}, 0);
        rst_n = 1'b1;
        idle(1'b0);

        // 1: single push, held head, then pop
        cycle(1'b1, 16'h0010, 16'h1234, 16'h2345, 16'h3456, 16'h4567, 4'b0, 1'b0, 1'b0);
        chk_state("t1_push");
        chk("t1_pc", {16'h0, pc_out}, 32'h0010);
        chk("t1_inst0", {16'h0, inst_out0}, 32'h1234);
        chk("t1_inst3", {16'h0, inst_out3}, 32'h4567);
        idle(1'b0);
        chk("t1_hold_pc", {16'h0, pc_out}, 32'h0010);
        idle(1'b1);
        chk_state("t1_pop");
        chk("t1_empty_pc", {16'h0, pc_out}, 0);

        // 2: fill to full, ignored 5th push, in-order drain
        for (int k = 0; k < 4; k++) push_b(16'(k * 4), 1'b0);
        chk_state("t2_full");
        chk("t2_stall", {31'h0, stall_fetch}, 1);
        push_b(16'h0010, 1'b0);
        chk("t2_fifth_count", {29'h0, count}, 4);
        idle(1'b1);
        chk("t2_stall_drop", {31'h0, stall_fetch}, 0);
        chk_state("t2_pop1");
        drain();

        // 3: all-zero bundle dropped, immediate jump in slot 1 removed
        cycle(1'b1, 16'h0020, 16'h0, 16'h0, 16'h0, 16'h0, 4'b0, 1'b0, 1'b0);
        chk("t3_zero_count", {29'h0, count}, 0);
        cycle(1'b1, 16'h0024, 16'h1111, 16'hF004, 16'h0, 16'h0, 4'b0100, 1'b0, 1'b0);
        chk("t3_inst0", {16'h0, inst_out0}, 32'h1111);
        chk("t3_inst1", {16'h0, inst_out1}, 32'h0000);
        drain();

        // 4: push+pop at full, push+pop at empty
        for (int k = 0; k < 4; k++) push_b(16'(16'h0100 + k * 4), 1'b0);
        push_b(16'h0200, 1'b1);
        chk("t4_full_pushpop", {29'h0, count}, 3);
        drain();
        push_b(16'h0300, 1'b1);
        chk("t4_empty_pushpop", {29'h0, count}, 1);
        drain();

        // 4b: pseudo-random traffic across pointer wrap
        for (int k = 0; k < 20; k++) begin
            if ($urandom_range(0, 1) == 1)
                push_b(16'(16'h0400 + k * 4), 1'($urandom_range(0, 1)));
            else
                idle(1'($urandom_range(0, 1)));
            chk("t4_rand_count", {29'h0, count}, mdl_cnt);
        end
        drain();

        // 5: flush together with push and dec_ready
        for (int k = 0; k < 3; k++) push_b(16'(16'h0500 + k * 4), 1'b0);
        chk("t5_pre_count", {29'h0, count}, 3);
        cycle(1'b1, 16'h0600, 16'h7777, 16'h0, 16'h0, 16'h0, 4'b0, 1'b1, 1'b1);
        chk_state("t5_flush");
        chk("t5_flush_count", {29'h0, count}, 0);
        idle(1'b1);
        chk_state("t5_after");

        // 6: asynchronous reset while full
        for (int k = 0; k < 4; k++) push_b(16'(16'h0700 + k * 4), 1'b0);
        chk("t6_pre_stall", {31'h0, stall_fetch}, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_stall", {31'h0, stall_fetch}, 0);
        chk("t6_valid", {31'h0, out_valid}, 0);
        chk("t6_count", {29'h0, count}, 0);
        chk("t6_pc", {16'h0, pc_out}, 0);
        exp_q.delete();
        mdl_cnt = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1'b1);
        chk_state("t6_after");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
